ps2_host_tx: RTL and testbench

// - PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 8'hED LED set, 8'hFF reset).
// - Drives open-drain clock/data enables.
// - Sits beside the PS/2 keyboard receiver on the same psClk/psData pins.
// - Frame: start(0), 8 data LSB-first, odd parity, stop(1), device ACK.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_sync_edge.sv | 32 +++
 rtl/ps2_host_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types, frame payload layout and keyboard command constants.
// Used by the host transmitter and the keyboard receiver on the same pins.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Payload shifted out after the start bit: data LSB first, then parity.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  localparam int unsigned PS2_FRAME_BITS = 9;
  localparam int unsigned PS2_STOP_INDEX = 9;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchroniser for a raw PS/2 pin with a one-cycle falling-edge pulse.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Reset to the idle (released) bus level so no edge is seen on exit from reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level  = sync[SYNC_STAGES-1];
  assign fall_c = prev & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte and checks the device ACK.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out frame up to MAX_RETRIES times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int unsigned MAX_RETRIES    = 2
`endif
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError,
  input  logic       psClk,
  input  logic       psData,
  output logic       psClk_oe,
  output logic       psData_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W = 4;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);
`endif

  ps2_tx_state_t             state, state_n;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_n;
  logic [BIT_W-1:0]          bit_cnt, bit_n;
  logic [INH_W-1:0]          inh_cnt, inh_n;
  logic [TMO_W-1:0]          tmo_cnt, tmo_n;
  logic                      busy_n, done_n, err_n, clk_oe_n, data_oe_n;
  logic                      fail, tmo_hit;
  ps2_frame_t                load;
`ifdef PS2_TX_RETRY_EN
  ps2_frame_t                latch_q, latch_n;
  logic [RTY_W-1:0]          retry_cnt, retry_n;
`endif

  logic clk_level, clk_fall, data_level, unused_data_fall;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (Clk),
    .reset  (reset),
    .din    (psClk),
    .level  (clk_level),
    .fall_c (clk_fall)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk    (Clk),
    .reset  (reset),
    .din    (psData),
    .level  (data_level),
    .fall_c (unused_data_fall)
  );

  // State, datapath and all outputs are registered here.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      txBusy    <= 1'b0;
      txDone    <= 1'b0;
      txError   <= 1'b0;
      psClk_oe  <= 1'b0;
      psData_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      latch_q   <= '0;
      retry_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      shift_q   <= shift_n;
      bit_cnt   <= bit_n;
      inh_cnt   <= inh_n;
      tmo_cnt   <= tmo_n;
      txBusy    <= busy_n;
      txDone    <= done_n;
      txError   <= err_n;
      psClk_oe  <= clk_oe_n;
      psData_oe <= data_oe_n;
`ifdef PS2_TX_RETRY_EN
      latch_q   <= latch_n;
      retry_cnt <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    bit_n       = bit_cnt;
    inh_n       = inh_cnt;
    tmo_n       = tmo_cnt;
    busy_n      = txBusy;
    done_n      = 1'b0;
    err_n       = 1'b0;
    clk_oe_n    = psClk_oe;
    data_oe_n   = psData_oe;
    fail        = 1'b0;
    load.parity = ps2_odd_parity(txData);
    load.data   = txData;
    tmo_hit     = !clk_fall && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`ifdef PS2_TX_RETRY_EN
    latch_n     = latch_q;
    retry_n     = retry_cnt;
`endif

    case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (txStart) begin
          shift_n  = load;
          busy_n   = 1'b1;
          clk_oe_n = 1'b1;
          inh_n    = '0;
          state_n  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          latch_n  = load;
          retry_n  = '0;
`endif
        end
      end

      INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_n = 1'b1;
          state_n   = START;
        end else begin
          inh_n = inh_cnt + INH_W'(1);
        end
      end

      // Start bit already on the data line; handing the clock to the device.
      START: begin
        clk_oe_n = 1'b0;
        bit_n    = '0;
        tmo_n    = '0;
        state_n  = XFER;
      end

      XFER: begin
        tmo_n = clk_fall ? '0 : tmo_cnt + TMO_W'(1);
        if (clk_fall) begin
          if (bit_cnt == BIT_W'(PS2_STOP_INDEX)) begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end else begin
            data_oe_n = ~shift_q[0];
            shift_n   = {1'b0, shift_q[PS2_FRAME_BITS-1:1]};
            bit_n     = bit_cnt + BIT_W'(1);
          end
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end

      ACK: begin
        tmo_n = clk_fall ? '0 : tmo_cnt + TMO_W'(1);
        if (clk_fall) begin
          if (!data_level) begin
            state_n = WAIT_IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end

      WAIT_IDLE: begin
        tmo_n = clk_fall ? '0 : tmo_cnt + TMO_W'(1);
        if (clk_level && data_level) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
    endcase

    // Abort: release both lines; retry from the inhibit phase while budget remains.
    if (fail) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      busy_n    = 1'b0;
      err_n     = 1'b1;
      state_n   = IDLE;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt < RTY_W'(MAX_RETRIES)) begin
        retry_n  = retry_cnt + RTY_W'(1);
        shift_n  = latch_q;
        inh_n    = '0;
        clk_oe_n = 1'b1;
        busy_n   = 1'b1;
        err_n    = 1'b0;
        state_n  = INHIBIT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a clock-generating PS/2 keyboard model.
// Expectations adapt to PS2_TX_RETRY_EN (three frames before an error).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TMO = 300;
  localparam int H   = 12;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       Clk;
  logic       reset;
  logic [7:0] txData;
  logic       txStart;
  logic       txBusy, txDone, txError;
  logic       psClk, psData, psClk_oe, psData_oe;
  logic       dev_clk_low, dev_data_low;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int err_cyc = 0, last_fall = 0;

  // Open-drain lines with pull-ups.
  assign psClk  = ~(psClk_oe | dev_clk_low);
  assign psData = ~(psData_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .txData    (txData),
    .txStart   (txStart),
    .txBusy    (txBusy),
    .txDone    (txDone),
    .txError   (txError),
    .psClk     (psClk),
    .psData    (psData),
    .psClk_oe  (psClk_oe),
    .psData_oe (psData_oe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (txDone) done_cnt++;
    if (txError) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (txDone && txError) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    txData  = d;
    txStart = 1'b1;
    @(negedge Clk);
    txStart = 1'b0;
    txData  = 8'h00;
  endtask

  // Count inhibit-only and start-bit cycles until the host releases the clock.
  task automatic wait_request(output int inh, output int st, output bit ok);
    inh = 0; st = 0; ok = 1'b0;
    for (int i = 0; i < INH + TMO + 200; i++) begin
      if (psClk_oe && !psData_oe) inh++;
      else if (psClk_oe && psData_oe) st++;
      else if (!psClk_oe && st > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  // Keyboard: samples start, then clocks nfalls falls sampling at each rise; fall 11 is the ACK.
  task automatic device_run(input int nfalls, input bit nack, output logic [10:0] bits);
    bits = '0;
    repeat (H) @(negedge Clk);
    bits[0] = psData;
    for (int k = 1; k <= 10 && k <= nfalls; k++) begin
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      repeat (H) @(negedge Clk);
      bits[k]     = psData;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge Clk);
    end
    if (nfalls >= 11) begin
      dev_data_low = !nack;
      repeat (H) @(negedge Clk);
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      repeat (H) @(negedge Clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge Clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!txBusy) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    @(negedge Clk);
  endtask

  task automatic run_good(input string tag, input logic [7:0] d, input logic [10:0] exp_bits,
                          input bit check_inh);
    int d0, e0, inh, st;
    bit ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send(d);
    chk({tag, "_busy"}, txBusy, 1);
    wait_request(inh, st, ok);
    chk({tag, "_req"}, ok, 1);
    if (check_inh) begin
      chk({tag, "_inhibit"}, inh, INH);
      chk({tag, "_start"}, st, 1);
    end
    device_run(11, 1'b0, bits);
    chk({tag, "_bits"}, bits, exp_bits);
    wait_idle(ok);
    chk({tag, "_idle"}, ok, 1);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_err"}, err_cnt - e0, 0);
    chk({tag, "_oe"}, {psClk_oe, psData_oe}, 0);
  endtask

  initial begin
    int d0, e0, inh, st, hold;
    bit ok;
    logic [10:0] bits;

    reset = 1'b1; txStart = 1'b0; txData = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", txBusy, 0);
    chk("rst_done", txDone, 0);
    chk("rst_err", txError, 0);
    chk("rst_clk_oe", psClk_oe, 0);
    chk("rst_data_oe", psData_oe, 0);
    reset = 1'b0;
    repeat (2) @(negedge Clk);

    // T1/T2: frames {stop, parity, data, start}, checked against hand-built words.
    run_good("t1_ed", PS2_CMD_SET_LED, 11'h7DA, 1'b1);
    run_good("t2_f4", PS2_CMD_ENABLE, 11'h5E8, 1'b1);
    run_good("t2_00", 8'h00, 11'h600, 1'b1);

    // T3: device NACKs every frame.
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_RESET);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_request(inh, st, ok);
      chk("t3_req", ok, 1);
      device_run(11, 1'b1, bits);
      chk("t3_bits", bits, 11'h7FE);
    end
    wait_idle(ok);
    chk("t3_idle", ok, 1);
    chk("t3_err", err_cnt - e0, 1);
    chk("t3_done", done_cnt - d0, 0);
    chk("t3_oe", {psClk_oe, psData_oe}, 0);

    // T4: device stops after data bit 4; error T counts after the synchronised fall + 3 latency.
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_ENABLE);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_request(inh, st, ok);
      chk("t4_req", ok, 1);
      device_run(5, 1'b0, bits);
      chk("t4_bits", bits[5:0], 6'h28);
    end
    ok = 1'b0;
    for (int i = 0; i < TMO + 50; i++) begin
      @(negedge Clk);
      if (err_cnt != e0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge Clk);
    chk("t4_seen", ok, 1);
    chk("t4_latency", err_cyc - last_fall, TMO + 3);
    chk("t4_err", err_cnt - e0, 1);
    chk("t4_done", done_cnt - d0, 0);
    chk("t4_oe", {psClk_oe, psData_oe}, 0);
    chk("t4_busy", txBusy, 0);

    // T5: reset in mid-transfer, coinciding with a start request.
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_SET_LED);
    wait_request(inh, st, ok);
    chk("t5_req", ok, 1);
    device_run(2, 1'b0, bits);
    chk("t5_pre_busy", txBusy, 1);
    chk("t5_pre_data_oe", psData_oe, 1);
    reset = 1'b1; txStart = 1'b1; txData = 8'h11;
    @(negedge Clk);
    chk("t5_rst_oe", {psClk_oe, psData_oe}, 0);
    chk("t5_rst_busy", txBusy, 0);
    reset = 1'b0; txStart = 1'b0; txData = 8'h00;
    repeat (20) @(negedge Clk);
    chk("t5_no_start", txBusy, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_err", err_cnt - e0, 0);
    run_good("t5_ed", PS2_CMD_SET_LED, 11'h7DA, 1'b1);

    // T6: second request while busy is dropped.
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_SET_LED);
    send(8'h11);
    wait_request(inh, st, ok);
    chk("t6_req", ok, 1);
    device_run(11, 1'b0, bits);
    chk("t6_bits", bits, 11'h7DA);
    wait_idle(ok);
    chk("t6_idle", ok, 1);
    hold = 0;
    for (int i = 0; i < 100; i++) begin
      if (psClk_oe || txBusy) hold++;
      @(negedge Clk);
    end
    chk("t6_no_second", hold, 0);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_err", err_cnt - e0, 0);

    chk("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
